// File: rtl/systolic_skew.sv
// systolic_skew: per-lane delay chains that skew (MODE 0) or deskew (MODE 1) a word.
// Optional drain/flush sequencer enabled by defining SYSTOLIC_SKEW_DRAIN_EN.
module systolic_skew #(
  parameter int DW    = 32,
  parameter int LANES = 4,
  parameter int MODE  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_valid,
  input  logic [LANES*DW-1:0]   i_data,
  input  logic                  i_drain,
  output logic [LANES*DW-1:0]   o_data,
  output logic [LANES-1:0]      o_valid,
  output logic                  o_busy,
  output logic                  o_drained
);

  logic feed_zero;

`ifdef SYSTOLIC_SKEW_DRAIN_EN
  localparam int CW = $clog2(LANES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          drained_q, drained_d;

  // drain sequencer state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      drained_q <= drained_d;
    end
  end

  // drain next state: load on request, count advances, pulse on completion
  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    drained_d = 1'b0;
    if (i_clr) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (i_en) begin
      if (!busy_q) begin
        if (i_drain) begin
          cnt_d  = CW'(LANES);
          busy_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d    = 1'b0;
          drained_d = 1'b1;
        end
      end
    end
  end

  // drain outputs come straight from registers
  always_comb begin
    feed_zero = busy_q;
    o_busy    = busy_q;
    o_drained = drained_q;
  end
`else
  logic unused_drain;

  assign unused_drain = i_drain;

  // drain feature absent: never flush, flags tied low
  always_comb begin
    feed_zero = 1'b0;
    o_busy    = 1'b0;
    o_drained = 1'b0;
  end
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D = (MODE == 0) ? k + 1 : LANES - k;

    logic [DW-1:0] dat_q [D];
    logic [D-1:0]  vld_q;
    logic [DW-1:0] lane_d;
    logic          vin_d;

    assign vin_d  = i_valid & ~feed_zero;
    assign lane_d = vin_d ? i_data[k*DW +: DW] : '0;

    // lane shift chain: clear wins, enable advances every stage together
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int j = 0; j < D; j++) dat_q[j] <= '0;
        vld_q <= '0;
      end else if (i_clr) begin
        for (int j = 0; j < D; j++) dat_q[j] <= '0;
        vld_q <= '0;
      end else if (i_en) begin
        dat_q[0] <= lane_d;
        vld_q[0] <= vin_d;
        for (int j = 1; j < D; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign o_data[k*DW +: DW] = dat_q[D-1];
    assign o_valid[k]         = vld_q[D-1];
  end

endmodule

// File: doc/systolic_skew.md
SYSTOLIC_SKEW -- requirements
Module: systolic_skew

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width per lane in bits.
REQ-002 The block SHALL have parameter LANES, default 4, legal range 1..16, meaning number of lanes.
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = skew (feed array), 1 = deskew (collect array).
REQ-004 The block SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_en, input, 1 bit: advance enable; when 0, all stages hold.
REQ-007 The block SHALL have port i_clr, input, 1 bit: synchronous clear of all stages.
REQ-008 The block SHALL have port i_valid, input, 1 bit: the i_data word is valid.
REQ-009 The block SHALL have port i_data, input, LANES*DW bits: lane k occupies bits [k*DW +: DW].
REQ-010 The block SHALL have port i_drain, input, 1 bit: drain request pulse.
REQ-011 The block SHALL have port o_data, output, LANES*DW bits: delayed lanes, same packing as i_data.
REQ-012 The block SHALL have port o_valid, output, LANES bits: per-lane valid, bit k for lane k.
REQ-013 The block SHALL have port o_busy, output, 1 bit: drain in progress.
REQ-014 The block SHALL have port o_drained, output, 1 bit: one-cycle pulse on drain completion.

Function
REQ-015 Lane k delay D(k) SHALL be k+1 advances in MODE 0 and LANES-k advances in MODE 1.
REQ-016 Each lane SHALL be a shift chain of D(k) data registers plus D(k) valid bits; the lane k input is (i_data lane k, i_valid).
REQ-017 An advance SHALL occur on a rising edge with i_en=1 and i_clr=0; all lanes shift by one stage together.
REQ-018 With i_en=0, all data, valid, and drain state SHALL hold unchanged.
REQ-019 i_clr=1 SHALL zero all data and valid stages and abort any drain (o_busy->0, no o_drained) at the next edge, regardless of i_en; i_clr has top priority after reset.
REQ-020 o_data lane k SHALL be the last data stage of lane k, and o_valid[k] SHALL be its last valid stage; outputs are registered with no combinational path from inputs.
REQ-021 A word presented with i_valid=0 SHALL be shifted in as zero data on every lane.
REQ-022 LANES=1 SHALL be legal and reduces the block to a single one-stage register.

Reset
REQ-023 i_rstn low SHALL asynchronously zero all data stages, valid stages, and the drain counter, and SHALL force o_data=0, o_valid=0, o_busy=0, o_drained=0.
REQ-024 Release of i_rstn SHALL be synchronous to i_clk; the first advance SHALL occur on the first qualifying edge after release.

Configuration
REQ-025 Macro SYSTOLIC_SKEW_DRAIN_EN SHALL control the drain feature.
REQ-026 With SYSTOLIC_SKEW_DRAIN_EN defined, i_drain=1 while o_busy=0 SHALL load a counter with maxD = LANES and set o_busy=1 at the next edge.
REQ-027 While o_busy=1, each advance SHALL force zero data and invalid input into every lane (ignoring i_data and i_valid) and decrement the counter.
REQ-028 When the counter reaches 0, o_busy SHALL fall, and o_drained SHALL pulse for exactly one cycle on the same edge.
REQ-029 i_drain SHALL be ignored while o_busy=1.
REQ-030 Without SYSTOLIC_SKEW_DRAIN_EN, i_drain SHALL be ignored and o_busy and o_drained SHALL be tied to 0, with the port list unchanged.

Verification
REQ-031 Skew scenario: MODE0, LANES=4, i_en=1; a single valid word with lanes {0x11,0x22,0x33,0x44} SHALL produce lane0=0x11 at edge+1, lane1=0x22 at +2, lane2=0x33 at +3, lane3=0x44 at +4, and each o_valid bit SHALL be high exactly one cycle.
REQ-032 Deskew scenario: MODE1, LANES=4; lane0 at T, lane1 at T+1, lane2 at T+2, lane3 at T+3 SHALL all appear together on o_data at T+4, with o_valid=4'hF for one cycle.
REQ-033 Stall scenario: after a valid word enters, i_en=0 for 3 cycles mid-flight SHALL hold outputs frozen, and the remaining latency SHALL resume unchanged when i_en returns to 1.
REQ-034 Clear scenario: i_clr asserted with 3 valid words in flight, i_en=0 in the same cycle, SHALL give o_valid=0 and o_data=0 on the next cycle, and no stale word SHALL emerge afterwards.
REQ-035 Drain scenario (macro on): i_drain with LANES=4 and i_valid=1 held SHALL give o_busy high for 4 advances, zero data entering, o_drained one pulse, and o_valid=0 after flush; a second i_drain during busy SHALL have no effect.
REQ-036 Reset scenario: asserting i_rstn low mid-drain and mid-stream SHALL clear all outputs immediately without waiting for a clock edge.
